// File: rtl/i2c_target_regs_pkg.sv
// Shared definitions for the I2C register target: FSM state encoding,
// bus-level constants and the register-file size.
package i2c_target_regs_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_ADDR_ACK,
    ST_REG_ADDR,
    ST_REG_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam int REG_COUNT = 16;

  function automatic logic ptr_in_range(input logic [7:0] p);
    return p < 8'(REG_COUNT);
  endfunction

endpackage

// File: rtl/i2c_target_regs_bus_sync.sv
// Bus front end: double-flop synchronizers for scl/sda, scl edge pulses and
// START/STOP condition pulses derived from the synchronized levels.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic sclRise,
  output logic sclFall,
  output logic startDet,
  output logic stopDet
);

  // [0] metastability flop, [1] synchronized level, [2] previous synchronized level
  logic [2:0] scl_q, scl_d;
  logic [2:0] sda_q, sda_d;

  always_comb begin
    scl_d = {scl_q[1:0], scl_in};
    sda_d = {sda_q[1:0], sda_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= scl_d;
      sda_q <= sda_d;
    end
  end

  assign sda_s    = sda_q[1];
  assign sclRise  =  scl_q[1] & ~scl_q[2];
  assign sclFall  = ~scl_q[1] &  scl_q[2];
  assign startDet =  scl_q[1] & ~sda_q[1] &  sda_q[2];
  assign stopDet  =  scl_q[1] &  sda_q[1] & ~sda_q[2];

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a 16 x 8-bit register file: register-pointer writes,
// burst writes and reads with auto-increment, plus a local debug read port.
module i2c_target_regs
  import i2c_target_regs_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic       wrStrobe,
  output logic [7:0] wrAddr,
  output logic [7:0] wrData,
  output logic       busy,
  input  logic [3:0] dbgAddr,
  output logic [7:0] dbgData
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl),
    .sda_in   (sda),
    .sda_s    (sda_s),
    .sclRise  (scl_rise),
    .sclFall  (scl_fall),
    .startDet (start_det),
    .stopDet  (stop_det)
  );

  i2c_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       commit_q, commit_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;

  logic [REG_COUNT-1:0][7:0] regs;
  logic [7:0] byte_in;
  logic [7:0] rd_byte;

  // The register file commits one cycle after the last data bit is sampled.
  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : g_reg
      logic [7:0] reg_q, reg_d;

      always_comb begin
        reg_d = reg_q;
        if (commit_q && ptr_q == 8'(gi)) begin
          reg_d = shift_q;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          reg_q <= 8'h00;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign regs[gi] = reg_q;
    end
  endgenerate

  assign byte_in = {shift_q[6:0], sda_s};
  assign rd_byte = ptr_in_range(ptr_q) ? regs[ptr_q[3:0]] : 8'hFF;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    commit_d    = 1'b0;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    if (commit_q) begin
      if (ptr_in_range(ptr_q)) begin
        wr_strobe_d = 1'b1;
        wr_addr_d   = ptr_q;
        wr_data_d   = shift_q;
      end
      ptr_d = ptr_q + 8'd1;
    end

    // Bus conditions override any bit activity seen in the same cycle.
    if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = ST_DEV_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ST_DEV_ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (byte_in[7:1] == DEV_ADDR) begin
                state_d = ST_ADDR_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end
        end

        // ACK states enter with sda released: first fall drives, second releases.
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (shift_q[0] == RW_READ) begin
              state_d   = ST_RD_DATA;
              shift_d   = rd_byte;
              ptr_d     = ptr_q + 8'd1;
              sda_oe_d  = ~rd_byte[7];
              bit_cnt_d = 4'd0;
            end else begin
              state_d  = ST_REG_ADDR;
              sda_oe_d = 1'b0;
            end
          end
        end

        ST_REG_ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              ptr_d     = byte_in;
              state_d   = ST_REG_ACK;
            end
          end
        end

        ST_REG_ACK, ST_WR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_WR_DATA;
            end
          end
        end

        ST_WR_DATA: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              commit_d  = 1'b1;
              state_d   = ST_WR_ACK;
            end
          end
        end

        ST_RD_DATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = ST_RD_ACK;
            end else if (bit_cnt_q != 4'd0) begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end

        ST_RD_ACK: begin
          if (scl_rise && sda_s == NACK) begin
            state_d = ST_IGNORE;
          end else if (scl_fall) begin
            state_d   = ST_RD_DATA;
            shift_d   = rd_byte;
            ptr_d     = ptr_q + 8'd1;
            sda_oe_d  = ~rd_byte[7];
            bit_cnt_d = 4'd0;
          end
        end

        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      ptr_q       <= 8'h00;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      commit_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      commit_q    <= commit_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign wrStrobe = wr_strobe_q;
  assign wrAddr   = wr_addr_q;
  assign wrData   = wr_data_q;
  assign busy     = busy_q;
  assign dbgData  = regs[dbgAddr];

endmodule
